// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: evaluator FSM encoding, default feedback polynomials
// per supported signature width, and a small helper for width-generic feedback.
package lbist_pkg;

  // Evaluator FSM states; encodings are fixed so other LBIST blocks can decode them.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } misr_state_t;

  // Default feedback tap masks (bit i set = XOR feedback into stage i).
  localparam logic [7:0]  POLY_8  = 8'h1D;
  localparam logic [15:0] POLY_16 = 16'h002D;
  localparam logic [22:0] POLY_23 = 23'h000021;
  localparam logic [23:0] POLY_24 = 24'h000087;

  // Start requests are honoured only when no session is in flight.
  function automatic logic start_allowed(input misr_state_t st);
    return (st == IDLE) || (st == DONE);
  endfunction

endpackage

// File: rtl/misr_sig_eval_if.sv
// Evaluator bus: session control from the LBIST controller, CUT response
// stream in, status and signature back out.
interface misr_sig_eval_if #(
  parameter int WIDTH = 24,
  parameter int PAT_W = 16
);
  logic             start;
  logic [PAT_W-1:0] pat_cnt;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  // Controller / CUT side drives the session and the response stream.
  modport master (
    output start, pat_cnt, din_valid, din, golden,
    input  busy, done, pass, signature
  );

  // Evaluator side.
  modport slave (
    input  start, pat_cnt, din_valid, din, golden,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/misr_core.sv
// Galois-form MISR register: WIDTH stages, XOR feedback taps from POLY,
// reloads SEED on reset or load, compacts one response vector per enabled cycle.
module misr_core #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = 24'h000087,
  parameter logic [WIDTH-1:0] SEED  = 24'h000064
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] feedback;
  logic [WIDTH-1:0] sig_next;

  // Feedback is applied only when the outgoing MSB is set.
  assign feedback = sig[WIDTH-1] ? POLY : '0;
  assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ din ^ feedback;

  // Signature register: seed load has priority over compaction.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled synchronously here, so it sits inside the clocked
    // branch rather than in the sensitivity list.
    if (rst || load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/misr_sig_eval.sv
// LBIST output evaluator: runs a session over pat_cnt CUT response vectors,
// compacts them in a MISR and compares the final signature with a golden value.
module misr_sig_eval
  import lbist_pkg::*;
#(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = POLY_24,
  parameter logic [WIDTH-1:0] SEED  = 24'h000064,
  parameter int               PAT_W = 16
) (
  input logic             clk,
  input logic             rst,
  misr_sig_eval_if.slave  bus
);

  misr_state_t      state;
  logic [PAT_W-1:0] remaining;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [WIDTH-1:0] sig;
  logic             accept_start;
  logic             compact_en;

  // A start is taken only between sessions; response vectors only while compacting.
  assign accept_start = bus.start && start_allowed(state);
  assign compact_en   = (state == COMPACT) && bus.din_valid;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept_start),
    .en   (compact_en),
    .din  (bus.din),
    .sig  (sig)
  );

  // Session FSM with pattern counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // NOTE: non-blocking assignments keep every register here updating
            // from the same pre-edge values, regardless of statement order.
            remaining <= bus.pat_cnt;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            state     <= (bus.pat_cnt == '0) ? COMPARE : COMPACT;
          end
        end
        COMPACT: begin
          // Gaps in din_valid simply stall the session; there is no timeout.
          if (bus.din_valid) begin
            remaining <= remaining - 1'b1;
            if (remaining == PAT_W'(1)) begin
              state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          pass_q <= (sig == bus.golden);
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule
